mult_booth32: RTL and testbench

Multicycle 32-bit signed multiplier for the execute stage, using radix-2 Booth recoding. Each iteration adds or subtracts the multiplicand through a 33-bit carry-lookahead adder built from the team's 8-bit CLA slices. It returns the low 32 bits of the product with a one-cycle ready pulse, and raises an overflow flag when the 64-bit product does not fit in 32 signed bits.

---
 rtl/mult_booth32_pkg.sv | 53 +++++
 rtl/cla_adder_33bit.sv | 38 +++
 rtl/mult_booth32.sv | 115 +++++++++++
 tb/tb_mult_booth32.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mult_booth32_pkg.sv
// mult_booth32_pkg: shared definitions for the radix-2 Booth multiplier.
//   - FSM state encodings (IDLE/RUN/DONE)
//   - Booth operation codes (NOP/ADD/SUB)
//   - ITER_LAST: counter value of the final Booth iteration
//   - 8-bit carry-lookahead slice helpers (group G/P and sum)
package mult_booth32_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    localparam int ITER_LAST = 31;

    // Group generate/propagate of an 8-bit slice. Kept separate from the
    // sum so the inter-slice lookahead never depends on a slice's own carry-in.
    function automatic logic [1:0] cla8_gp(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] g;
        logic [7:0] p;
        logic       gg;
        logic       pg;
        g  = a & b;
        p  = a ^ b;
        gg = 1'b0;
        pg = 1'b1;
        for (int i = 0; i < 8; i++) begin
            gg = g[i] | (p[i] & gg);
            pg = pg & p[i];
        end
        return {gg, pg};
    endfunction

    // Sum of an 8-bit slice given its carry-in.
    function automatic logic [7:0] cla8_sum(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [8:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return p ^ c[7:0];
    endfunction

endpackage

// File: rtl/cla_adder_33bit.sv
// cla_adder_33bit: 33-bit adder from four 8-bit CLA slices with a second
// level of group G/P lookahead between slices, plus a single top bit.
// Carry-out of bit 32 is discarded.
//   a, b : 33-bit addends
//   cin  : carry into bit 0
//   sum  : 33-bit result
module cla_adder_33bit
    import mult_booth32_pkg::*;
(
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        cin,
    output logic [32:0] sum
);

    logic [3:0] gg;
    logic [3:0] pg;
    logic [4:0] c;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            {gg[k], pg[k]} = cla8_gp(a[8*k +: 8], b[8*k +: 8]);
        end
        c[0] = cin;
        c[1] = gg[0] | (pg[0] & cin);
        c[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        c[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
             | (pg[2] & pg[1] & pg[0] & cin);
        c[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
             | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            sum[8*k +: 8] = cla8_sum(a[8*k +: 8], b[8*k +: 8], c[k]);
        end
        sum[32] = a[32] ^ b[32] ^ c[4];
    end

endmodule

// File: rtl/mult_booth32.sv
// mult_booth32: multicycle 32x32 signed multiplier, radix-2 Booth, one
// iteration per clock (33-cycle issue period).
//   clock          : rising-edge clock
//   reset          : asynchronous active-low reset
//   ctrl_MULT      : start strobe; also aborts/restarts a running operation
//   dataA, dataB   : multiplicand / multiplier, latched on the start edge
//   data_result    : product[31:0]
//   data_exception : product does not fit in 32 signed bits
//   data_resultRDY : one-cycle completion pulse
module mult_booth32
    import mult_booth32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = ITER_LAST + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam logic [5:0] CNT_LAST = 6'(ITER - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [5:0]       cnt_q, cnt_d;

    booth_op_e        op;
    logic [WIDTH:0]   addend;
    logic             add_cin;
    logic [WIDTH:0]   sum;

    // Subtract is A + ~M + 1; the +1 rides in on the adder carry-in.
    always_comb begin
        unique case ({q_q[0], q1_q})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        addend  = (op == BOOTH_ADD) ? m_q : (op == BOOTH_SUB) ? ~m_q : '0;
        add_cin = (op == BOOTH_SUB);
    end

    cla_adder_33bit u_add (
        .a   (a_q),
        .b   (addend),
        .cin (add_cin),
        .sum (sum)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        // A start strobe wins in every state, so a running job is simply
        // overwritten and never reaches DONE.
        if (ctrl_MULT) begin
            state_d = ST_RUN;
            m_d     = {dataA[WIDTH-1], dataA};
            a_d     = '0;
            q_d     = dataB;
            q1_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    // Arithmetic shift of {sum, Q, q_1} right by one.
                    a_d   = {sum[WIDTH], sum[WIDTH:1]};
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == CNT_LAST) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are decoded from registers only. The product fits in 32 signed
    // bits exactly when the upper word and result sign bit all agree.
    assign data_result    = q_q;
    assign data_exception = ~((&{a_q[WIDTH-1:0], q_q[WIDTH-1]}) |
                              ~(|{a_q[WIDTH-1:0], q_q[WIDTH-1]}));
    assign data_resultRDY = (state_q == ST_DONE);

endmodule

// File: tb/tb_mult_booth32.sv
// tb_mult_booth32: scoreboard bench for mult_booth32. Stimulus pushes the
// expected result, overflow flag and completion cycle; a monitor branch pops
// and compares on every ready pulse.
module tb_mult_booth32;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct {
        logic [31:0] r;
        logic        e;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    mult_booth32 #(.WIDTH(32), .ITER(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .dataA          (dataA),
        .dataB          (dataB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Directed vectors with hand-computed products.
    logic [31:0] va [5] = '{32'd3, 32'hFFFFFFF9, 32'h80000000, 32'h00010000, 32'h80000000};
    logic [31:0] vb [5] = '{32'd5, 32'd6,        32'hFFFFFFFF, 32'h00010000, 32'd1};
    logic [31:0] vr [5] = '{32'd15, 32'hFFFFFFD6, 32'h80000000, 32'h00000000, 32'h80000000};
    logic        ve [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Called at a negedge; the start is sampled on the following posedge, and
    // the ready pulse is visible at the negedge 33 cycles after the call.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] r, input logic e, input bit push);
        exp_t x;
        ctrl_MULT = 1'b1;
        dataA     = a;
        dataB     = b;
        if (push) begin
            x.r   = r;
            x.e   = e;
            x.due = cyc + 33;
            sb.push_back(x);
        end
        @(negedge clock);
        ctrl_MULT = 1'b0;
        dataA     = ~a;
        dataB     = 32'h5A5A5A5A;
    endtask

    initial begin
        bit   prev_rdy;
        exp_t x;
        checks    = 0;
        errors    = 0;
        prev_rdy  = 1'b0;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        dataA     = '0;
        dataB     = '0;
        fork
            begin : monitor
                forever begin
                    @(negedge clock);
                    if (reset && data_resultRDY) begin
                        checks++;
                        if (prev_rdy) begin
                            errors++;
                            $display("FAIL rdy_width: ready high %0d cycles in a row, required 1", 2);
                        end
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pulse: got ready at cycle %0d, required none", cyc);
                        end else begin
                            x = sb.pop_front();
                            checks += 3;
                            if (data_result !== x.r) begin
                                errors++;
                                $display("FAIL result: got %h, required %h", data_result, x.r);
                            end
                            if (data_exception !== x.e) begin
                                errors++;
                                $display("FAIL exception: got %b, required %b", data_exception, x.e);
                            end
                            if (cyc != x.due) begin
                                errors++;
                                $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, x.due);
                            end
                        end
                    end
                    prev_rdy = data_resultRDY;
                end
            end
            begin : stimulus
                repeat (3) @(negedge clock);
                checks += 3;
                if (data_result !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_result: got %h, required 0", data_result);
                end
                if (data_exception !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_exception: got %b, required 0", data_exception);
                end
                if (data_resultRDY !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_rdy: got %b, required 0", data_resultRDY);
                end
                reset = 1'b1;
                @(negedge clock);

                // Back-to-back issue: each new start lands in the DONE cycle.
                for (int i = 0; i < 5; i++) begin
                    start_op(va[i], vb[i], vr[i], ve[i], 1'b1);
                    repeat (32) @(negedge clock);
                end
                repeat (40) @(negedge clock);

                // Abort: 3x5 overwritten ten cycles in by 4x4.
                start_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
                repeat (9) @(negedge clock);
                start_op(32'd4, 32'd4, 32'd16, 1'b0, 1'b1);
                repeat (45) @(negedge clock);

                // Reset twenty cycles into a run: outputs clear, no pulse follows.
                start_op(32'd7, 32'd9, 32'd0, 1'b0, 1'b0);
                repeat (19) @(negedge clock);
                reset = 1'b0;
                #1;
                checks += 3;
                if (data_result !== 32'd0) begin
                    errors++;
                    $display("FAIL midrun_reset_result: got %h, required 0", data_result);
                end
                if (data_exception !== 1'b0) begin
                    errors++;
                    $display("FAIL midrun_reset_exception: got %b, required 0", data_exception);
                end
                if (data_resultRDY !== 1'b0) begin
                    errors++;
                    $display("FAIL midrun_reset_rdy: got %b, required 0", data_resultRDY);
                end
                @(negedge clock);
                reset = 1'b1;
                repeat (45) @(negedge clock);

                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL missing_pulses: %0d results outstanding, required 0", sb.size());
                end
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
